// File: rtl/mem_bist_if.sv
// Memory-side bus between the BIST controller and a single-port memory.
// The controller owns address, write data and write enable; the memory
// returns read data.
interface mem_bist_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data_input;
  logic                  mem_write_enable;
  logic [DATA_WIDTH-1:0] mem_data_output;

  modport master (
    output mem_address,
    output mem_data_input,
    output mem_write_enable,
    input  mem_data_output
  );

  modport slave (
    input  mem_address,
    input  mem_data_input,
    input  mem_write_enable,
    output mem_data_output
  );
endinterface

// File: rtl/mem_bist_ctrl.sv
// Built-in self-test controller for a single-port memory.
// On start: clear every word, then write/readback a checkerboard per address,
// then verify the whole array again. Counts mismatches (saturating) and
// latches the address of the first one.
module mem_bist_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 1,
  parameter int ERR_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,          // asynchronous, active low
  input  logic                  start,
  mem_bist_if.master            mem,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_WIDTH-1:0]  error_count,
  output logic                  first_err_valid,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_TWR, S_TRD, S_VRD, S_DONE
  } state_t;

  // One extra address bit so the sweep end is never confused with a wrap.
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam int                  LAT_W     = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam logic [LAT_W-1:0]    LAT_LAST  = LAT_W'(READ_LATENCY);
  localparam logic [ERR_WIDTH-1:0] ERR_MAX  = {ERR_WIDTH{1'b1}};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   addr_q, addr_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [ERR_WIDTH-1:0]  err_q, err_d;
  logic                  ferr_valid_q, ferr_valid_d;
  logic [ADDR_WIDTH-1:0] ferr_addr_q, ferr_addr_d;

  logic                  we;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] exp_word;
  logic                  last_addr;
  logic                  sample;
  logic                  mismatch;

  // Checkerboard: all-ones at even addresses, all-zeros at odd ones.
  assign exp_word  = {DATA_WIDTH{~addr_q[0]}};
  assign last_addr = (addr_q == LAST_ADDR);
  assign mismatch  = sample && (mem.mem_data_output != exp_word);

  // State and result registers; reset aborts a run and drops everything.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      lat_q        <= '0;
      err_q        <= '0;
      ferr_valid_q <= 1'b0;
      ferr_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      lat_q        <= lat_d;
      err_q        <= err_d;
      ferr_valid_q <= ferr_valid_d;
      ferr_addr_q  <= ferr_addr_d;
    end
  end

  // Next-state, memory drive and mismatch bookkeeping.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    addr_d       = addr_q;
    lat_d        = lat_q;
    err_d        = err_q;
    ferr_valid_d = ferr_valid_q;
    ferr_addr_d  = ferr_addr_q;
    we           = 1'b0;
    din          = '0;
    sample       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_CLEAR;
          addr_d       = '0;
          lat_d        = '0;
          err_d        = '0;
          ferr_valid_d = 1'b0;
          ferr_addr_d  = '0;
        end
      end
      S_CLEAR: begin
        we = 1'b1;
        if (last_addr) begin
          state_d = S_TWR;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_TWR: begin
        we      = 1'b1;
        din     = exp_word;
        lat_d   = '0;
        state_d = S_TRD;
      end
      S_TRD, S_VRD: begin
        if (lat_q == LAT_LAST) begin
          sample = 1'b1;
          lat_d  = '0;
          if (!last_addr) begin
            addr_d  = addr_q + 1'b1;
            state_d = (state_q == S_TRD) ? S_TWR : S_VRD;
          end else if (state_q == S_TRD) begin
            addr_d  = '0;
            state_d = S_VRD;
          end else begin
            addr_d  = '0;
            state_d = S_DONE;
          end
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (mismatch) begin
      if (err_q != ERR_MAX) err_d = err_q + 1'b1;
      if (!ferr_valid_q) begin
        ferr_valid_d = 1'b1;
        ferr_addr_d  = addr_q[ADDR_WIDTH-1:0];
      end
    end
  end

  // Write enable comes straight from state so reset removes it at once.
  assign mem.mem_address      = addr_q[ADDR_WIDTH-1:0];
  assign mem.mem_data_input   = din;
  assign mem.mem_write_enable = we;

  assign busy            = (state_q == S_CLEAR) || (state_q == S_TWR) ||
                           (state_q == S_TRD)   || (state_q == S_VRD);
  assign done            = (state_q == S_DONE);
  assign pass            = done && (err_q == '0);
  assign error_count     = err_q;
  assign first_err_valid = ferr_valid_q;
  assign first_err_addr  = ferr_addr_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl with a 16-word, latency-1 memory model
// that can inject faults, plus a second instance with a 3-bit error counter
// reading from an all-zeros memory.
module tb_mem_bist_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic sat_start = 1'b0;

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // ---------------- main DUT ----------------
  mem_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic          busy, done, pass, fev;
  logic [15:0]   ec;
  logic [AW-1:0] fea;

  mem_bist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .ERR_WIDTH(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .mem             (bus),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .error_count     (ec),
    .first_err_valid (fev),
    .first_err_addr  (fea)
  );

  // Memory model: 0 = clean, 1 = data bit 2 stuck-at-0, 2 = address bit 0 ignored.
  int            mode = 0;
  logic [DW-1:0] mem_arr [16];
  logic [DW-1:0] rd_q;
  logic [AW-1:0] eff_addr;

  assign eff_addr = (mode == 2) ? {bus.mem_address[AW-1:1], 1'b0} : bus.mem_address;

  always @(posedge clk) begin
    if (bus.mem_write_enable) mem_arr[eff_addr] <= bus.mem_data_input;
    rd_q <= mem_arr[eff_addr];
  end

  assign bus.mem_data_output = (mode == 1) ? (rd_q & 8'hFB) : rd_q;

  // ---------------- saturation DUT ----------------
  mem_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

  logic          sat_busy, sat_done, sat_pass, sat_fev;
  logic [2:0]    sat_ec;
  logic [AW-1:0] sat_fea;

  mem_bist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .ERR_WIDTH(3)) dut_sat (
    .clk             (clk),
    .reset           (reset),
    .start           (sat_start),
    .mem             (bus2),
    .busy            (sat_busy),
    .done            (sat_done),
    .pass            (sat_pass),
    .error_count     (sat_ec),
    .first_err_valid (sat_fev),
    .first_err_addr  (sat_fea)
  );

  assign bus2.mem_data_output = 8'h00;

  logic [2:0] sat_prev = 3'd0;
  logic       sat_wrapped = 1'b0;
  always @(negedge clk) begin
    if (sat_busy && (sat_ec < sat_prev)) sat_wrapped = 1'b1;
    sat_prev = sat_ec;
  end

  // ---------------- helpers ----------------
  task automatic pulse_start;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Counts busy cycles until busy falls, bounded.
  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) break;
      cycles++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #1;
    total++; if (bus.mem_write_enable !== 1'b0) $display("FAIL reset_we: got %b want 0", bus.mem_write_enable); else passed++;
    total++; if (bus.mem_address !== 4'h0) $display("FAIL reset_addr: got %h want 0", bus.mem_address); else passed++;
    total++; if ({busy, done, pass, fev} !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", {busy, done, pass, fev}); else passed++;
    total++; if (ec !== 16'd0) $display("FAIL reset_ec: got %0d want 0", ec); else passed++;
    @(posedge clk); @(negedge clk); reset = 1'b1;
    @(negedge clk);
    total++; if ({busy, done} !== 2'b00) $display("FAIL idle_flags: got %b want 00", {busy, done}); else passed++;
  endtask

  task automatic test_clean_run;
    int k;
    mode = 0;
    pulse_start();
    k = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) break;
      if (k == 0) begin
        total++; if ({bus.mem_write_enable, bus.mem_data_input, bus.mem_address} !== {1'b1, 8'h00, 4'h0})
          $display("FAIL clear_first: got we=%b d=%h a=%h want we=1 d=00 a=0", bus.mem_write_enable, bus.mem_data_input, bus.mem_address); else passed++;
      end
      if (k == 15) begin
        total++; if ({bus.mem_write_enable, bus.mem_address} !== {1'b1, 4'hF})
          $display("FAIL clear_last: got we=%b a=%h want we=1 a=f", bus.mem_write_enable, bus.mem_address); else passed++;
      end
      if (k == 16) begin
        total++; if ({bus.mem_write_enable, bus.mem_data_input, bus.mem_address} !== {1'b1, 8'hFF, 4'h0})
          $display("FAIL twr0: got we=%b d=%h a=%h want we=1 d=ff a=0", bus.mem_write_enable, bus.mem_data_input, bus.mem_address); else passed++;
      end
      if (k == 17) begin
        total++; if ({bus.mem_write_enable, bus.mem_address} !== {1'b0, 4'h0})
          $display("FAIL trd0: got we=%b a=%h want we=0 a=0", bus.mem_write_enable, bus.mem_address); else passed++;
      end
      if (k == 19) begin
        total++; if ({bus.mem_write_enable, bus.mem_data_input, bus.mem_address} !== {1'b1, 8'h00, 4'h1})
          $display("FAIL twr1: got we=%b d=%h a=%h want we=1 d=00 a=1", bus.mem_write_enable, bus.mem_data_input, bus.mem_address); else passed++;
      end
      if (k == 64) begin
        total++; if ({bus.mem_write_enable, bus.mem_address} !== {1'b0, 4'h0})
          $display("FAIL vrd0: got we=%b a=%h want we=0 a=0", bus.mem_write_enable, bus.mem_address); else passed++;
      end
      k++;
    end
    total++; if (k !== 96) $display("FAIL clean_cycles: got %0d want 96", k); else passed++;
    total++; if ({done, pass, fev} !== 3'b110) $display("FAIL clean_status: got done/pass/fev=%b want 110", {done, pass, fev}); else passed++;
    total++; if (ec !== 16'd0) $display("FAIL clean_ec: got %0d want 0", ec); else passed++;
  endtask

  task automatic test_stuck_bit;
    int cyc;
    mode = 1;
    pulse_start();
    wait_done(cyc);
    total++; if (ec !== 16'd16) $display("FAIL stuck_ec: got %0d want 16", ec); else passed++;
    total++; if ({done, pass, fev} !== 3'b101) $display("FAIL stuck_status: got done/pass/fev=%b want 101", {done, pass, fev}); else passed++;
    total++; if (fea !== 4'h0) $display("FAIL stuck_fea: got %h want 0", fea); else passed++;
  endtask

  // Start in DONE (after the faulty run) must clear results and restart.
  task automatic test_restart_from_done;
    int cyc;
    mode = 0;
    pulse_start();
    total++; if ({busy, done, pass, fev} !== 4'b1000) $display("FAIL restart_flags: got %b want 1000", {busy, done, pass, fev}); else passed++;
    total++; if ({ec, fea} !== 20'd0) $display("FAIL restart_results: got ec=%0d fea=%h want 0/0", ec, fea); else passed++;
    wait_done(cyc);
    total++; if ({cyc, pass} !== {32'd96, 1'b1}) $display("FAIL restart_run: got cycles=%0d pass=%b want 96/1", cyc, pass); else passed++;
  endtask

  task automatic test_alias;
    int cyc;
    mode = 2;
    pulse_start();
    wait_done(cyc);
    total++; if (ec !== 16'd8) $display("FAIL alias_ec: got %0d want 8", ec); else passed++;
    total++; if ({pass, fev, fea} !== {1'b0, 1'b1, 4'h0}) $display("FAIL alias_status: got pass=%b fev=%b fea=%h want 0/1/0", pass, fev, fea); else passed++;
  endtask

  task automatic test_saturation;
    int k;
    @(posedge clk); #1 sat_start = 1'b1;
    @(posedge clk); #1 sat_start = 1'b0;
    k = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!sat_busy) break;
      k++;
    end
    total++; if (sat_ec !== 3'd7) $display("FAIL sat_ec: got %0d want 7", sat_ec); else passed++;
    total++; if (sat_wrapped !== 1'b0) $display("FAIL sat_wrap: got %b want 0", sat_wrapped); else passed++;
    total++; if ({sat_done, sat_pass, sat_fev, sat_fea} !== {3'b101, 4'h0})
      $display("FAIL sat_status: got done/pass/fev=%b fea=%h want 101/0", {sat_done, sat_pass, sat_fev}, sat_fea); else passed++;
  endtask

  task automatic test_reset_mid_run;
    int  cyc;
    bit  found;
    mode = 0;
    found = 1'b0;
    pulse_start();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy && !bus.mem_write_enable && bus.mem_address == 4'h5) begin
        found = 1'b1;
        break;
      end
    end
    total++; if (found !== 1'b1) $display("FAIL midrst_reach: got %b want 1", found); else passed++;
    reset = 1'b0;
    #1;
    total++; if ({bus.mem_write_enable, bus.mem_data_input, bus.mem_address} !== 13'd0)
      $display("FAIL midrst_bus: got we=%b d=%h a=%h want 0", bus.mem_write_enable, bus.mem_data_input, bus.mem_address); else passed++;
    total++; if ({busy, done, pass, fev, ec, fea} !== 24'd0)
      $display("FAIL midrst_outputs: got busy=%b done=%b ec=%0d want 0", busy, done, ec); else passed++;
    @(posedge clk); @(negedge clk); reset = 1'b1;
    pulse_start();
    wait_done(cyc);
    total++; if ({cyc, pass, ec} !== {32'd96, 1'b1, 16'd0}) $display("FAIL midrst_rerun: got cycles=%0d pass=%b ec=%0d want 96/1/0", cyc, pass, ec); else passed++;
  endtask

  task automatic test_start_while_busy;
    int k;
    mode = 0;
    pulse_start();
    k = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) break;
      if (k == 10) start = 1'b1;
      if (k == 11) start = 1'b0;
      if (k == 70) start = 1'b1;
      if (k == 71) start = 1'b0;
      k++;
    end
    total++; if (k !== 96) $display("FAIL busy_start_cycles: got %0d want 96", k); else passed++;
    total++; if ({done, pass, fev, ec} !== {3'b110, 16'd0}) $display("FAIL busy_start_status: got done/pass/fev=%b ec=%0d want 110/0", {done, pass, fev}, ec); else passed++;
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_stuck_bit();
    test_restart_from_done();
    test_alias();
    test_saturation();
    test_reset_mid_run();
    test_start_while_busy();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_bist_ctrl.md
Name: mem_bist_ctrl

Overview:
- Hardware built-in self-test controller that sits directly upstream of the single-port `memory` block.
- It drives the memory's address, data_input and write_enable pins, and consumes data_output.
- On `start` it runs three phases: clear, write/readback, then a full verify sweep. It counts mismatches and records the first failing address.
- It replaces the simulation-only checkerboard check with synthesizable logic usable at power-on.

Parameters:
- DATA_WIDTH, 8: memory word width.
- ADDR_WIDTH, 16: memory address width. RAM_DEPTH = 1 << ADDR_WIDTH, derived internally.
- READ_LATENCY, 1: number of clk edges between presenting a read address and data_output being valid (0 = combinational read).
- ERR_WIDTH, 16: width of the saturating error counter.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  one-cycle pulse; begins a test run when idle.
- mem_address  output  ADDR_WIDTH  to memory.address.
- mem_data_input  output  DATA_WIDTH  to memory.data_input.
- mem_write_enable  output  1  to memory.write_enable; memory writes on the rising clk edge while this is high.
- mem_data_output  input  DATA_WIDTH  from memory.data_output.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  high after a run completes; held until the next accepted start or reset.
- pass  output  1  done && error_count==0; held with done.
- error_count  output  ERR_WIDTH  mismatches in this run; saturates at all-ones.
- first_err_valid  output  1  high once any mismatch has been recorded in this run.
- first_err_addr  output  ADDR_WIDTH  address of the first mismatch; valid when first_err_valid is high.

Behaviour:
- Reset values (reset low, asynchronous): every output is 0, state = IDLE. mem_write_enable must drop immediately, without waiting for clk.
- Expected pattern: exp(a) = all-ones if a[0]==0, all-zeros if a[0]==1. This is the alternating checkerboard starting with 0xFF at address 0.
- IDLE:
  - start=1 → CLEAR with addr=0.
  - On acceptance, done, pass, error_count, first_err_valid and first_err_addr clear to 0.
  - start is ignored in every state other than IDLE and DONE.
- CLEAR:
  - One cycle per address: mem_write_enable=1, mem_data_input=0, mem_address=addr.
  - After addr==RAM_DEPTH-1 → TWR with addr=0.
- TWR: one write cycle with mem_write_enable=1 and mem_data_input=exp(addr) → TRD.
- TRD:
  - Holds mem_write_enable=0 and mem_address=addr for READ_LATENCY+1 cycles.
  - Samples mem_data_input-independent data, mem_data_output, in the last of those cycles and compares it to exp(addr).
  - Then → TWR with addr+1, or → VRD with addr=0 after the last address.
- VRD: read-only sweep with the same READ_LATENCY+1-cycle read and compare per address. After the last address → DONE.
- DONE: busy=0, done=1, pass valid. start → new run, same as from IDLE.
- Mismatch handling:
  - error_count increments by 1 and saturates; it never wraps.
  - If first_err_valid==0, latch first_err_addr=addr and set first_err_valid=1. Later mismatches do not alter it.
- Address counter is ADDR_WIDTH+1 bits internally so the end-of-sweep test has no wrap ambiguity.
- Run length: RAM_DEPTH × (1 + 1 + (READ_LATENCY+1) + (READ_LATENCY+1)) cycles from the first CLEAR cycle. For ADDR_WIDTH=4, READ_LATENCY=1 this is 96 cycles.
- Reset mid-run: aborts immediately to IDLE with all outputs 0. No partial results are retained.
- X or Z on mem_data_output counts as a mismatch (case-inequality semantics in the comparison model). RTL compares 2-state bits.

Test Plan:
- Fault-free memory model (ADDR_WIDTH=4, READ_LATENCY=1), start pulse → busy for exactly 96 cycles, then done=1, pass=1, error_count=0, first_err_valid=0.
- Memory model with data bit 2 stuck-at-0 → error_count=16 (8 even addresses in the write/readback phase + 8 in verify), first_err_addr=0, pass=0.
- Memory model ignoring address bit 0 (pairs alias) → write/readback phase clean; verify reads 0x00 at every even address → error_count=8, first_err_addr=0, pass=0.
- ERR_WIDTH=3 with an all-zeros stuck memory → error_count saturates at 7 and never wraps, first_err_addr=0.
- Assert reset low during the TRD phase at address 5 → mem_write_enable falls before the next clk edge and all outputs are 0. After release, start → full clean run with pass=1.
- Pulse start again while busy → ignored: run completes at the original cycle count with unchanged results. Start while in DONE clears the results and restarts.
